// File: rtl/fib_ser_pkg.sv
// Shared types and constants for the Fibonacci byte serializer.
// Build option: FIB_SER_PARITY_EN appends an even-parity bit after the MSB of each frame.
package fib_ser_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

`ifdef FIB_SER_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  localparam int         FRAME_BITS = 8 + PARITY_BITS;
  localparam logic [7:0] DROP_MAX   = 8'hFF;

endpackage

// File: rtl/fib_byte_serializer_if.sv
// Producer byte handshake plus serial consumer handshake of the byte serializer.
interface fib_byte_serializer_if #(parameter int DATA_W = 8);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              ser_ready;
  logic              ser_valid;
  logic              ser_out;
  logic              ser_start;
  logic [7:0]        drop_cnt;

  modport slave (
    input  in_valid, in_data, ser_ready,
    output in_ready, ser_valid, ser_out, ser_start, drop_cnt
  );

  modport master (
    output in_valid, in_data, ser_ready,
    input  in_ready, ser_valid, ser_out, ser_start, drop_cnt
  );

endinterface

// File: rtl/fib_ser_fifo.sv
// Synchronous FIFO buffering producer bytes; head is the oldest entry, valid while !empty.
module fib_ser_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers are exactly AW bits wide, so power-of-two wrap is free.
  always_comb begin
    wr_d  = wr_q + AW'(do_push);
    rd_d  = rd_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/fib_byte_serializer.sv
// Buffers generator bytes and shifts them out LSB first with a start strobe per frame.
// Build option: FIB_SER_PARITY_EN adds a trailing even-parity bit to every frame.
module fib_byte_serializer
  import fib_ser_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  fib_byte_serializer_if.slave  bus
);

  localparam int FB = DATA_W + PARITY_BITS;
  localparam int IW = $clog2(FB);

  state_e            state_q, state_d;
  logic [FB-1:0]     shift_q, shift_d, load_frame;
  logic [IW-1:0]     idx_q, idx_d;
  logic [7:0]        drop_q, drop_d;
  logic              full, empty, pop;
  logic [DATA_W-1:0] head;

  fib_ser_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.in_valid && !full),
    .push_data (bus.in_data),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

`ifdef FIB_SER_PARITY_EN
  assign load_frame = {^head, head};
`else
  assign load_frame = head;
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = load_frame;
          idx_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.ser_ready) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + IW'(1);
          // Reload on the last bit's edge so back-to-back frames have no gap.
          if (idx_q == IW'(FB-1)) begin
            idx_d = '0;
            if (!empty) begin
              pop     = 1'b1;
              shift_d = load_frame;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    drop_d = drop_q;
    if (bus.in_valid && full && drop_q != DROP_MAX) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
    end
  end

  // The shift register drains to zero by frame end, so ser_out idles low.
  assign bus.in_ready  = !full;
  assign bus.ser_valid = (state_q == SHIFT);
  assign bus.ser_out   = shift_q[0];
  assign bus.ser_start = (state_q == SHIFT) && (idx_q == '0);
  assign bus.drop_cnt  = drop_q;

endmodule

// File: tb/tb_fib_byte_serializer.sv
// Randomized self-checking bench for fib_byte_serializer against a queue-based frame model.
module tb_fib_byte_serializer;

  localparam int DEPTH = 4;
  localparam int DW    = 8;
`ifdef FIB_SER_PARITY_EN
  localparam int FB = DW + 1;
`else
  localparam int FB = DW;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fib_byte_serializer_if #(.DATA_W(DW)) bus ();

  fib_byte_serializer #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // Model: byte queue, current frame as a bit vector, and its bit position.
  logic [7:0]    mq[$];
  bit            m_busy;
  logic [FB-1:0] m_frame;
  int            m_pos;
  int            m_drops;

  function automatic logic [FB-1:0] mk_frame(logic [7:0] b);
    logic [FB-1:0] f;
    f = '0;
    for (int i = 0; i < 8; i++) f[i] = b[i];
`ifdef FIB_SER_PARITY_EN
    f[FB-1] = ($countones(b) % 2) == 1;
`endif
    return f;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_busy  = 1'b0;
    m_frame = '0;
    m_pos   = 0;
    m_drops = 0;
  endfunction

  function automatic void model_step(bit v, logic [7:0] d, bit r);
    bit acc, last, take;
    acc  = v && (mq.size() < DEPTH);
    if (v && !acc && m_drops < 255) m_drops++;
    last = m_busy && r && (m_pos == FB-1);
    take = (!m_busy || last) && (mq.size() != 0);
    if (m_busy && r) begin
      if (last) m_busy = 1'b0;
      else      m_pos++;
    end
    if (take) begin
      m_frame = mk_frame(mq.pop_front());
      m_pos   = 0;
      m_busy  = 1'b1;
    end
    if (acc) mq.push_back(d);
  endfunction

  task automatic tick(input bit v, input logic [7:0] d, input bit r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.ser_ready = r;
    @(posedge clk);
    model_step(v, d, r);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_data = '0; bus.ser_ready = 1'b0;
    #1 rst = 1'b0;
    #1;
    model_reset();
    compared += 5;
    if (bus.ser_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %b want 0", bus.ser_valid); end
    if (bus.ser_out !== 1'b0)   begin mismatched++; $display("FAIL reset_out got %b want 0", bus.ser_out); end
    if (bus.ser_start !== 1'b0) begin mismatched++; $display("FAIL reset_start got %b want 0", bus.ser_start); end
    if (bus.drop_cnt !== 8'd0)  begin mismatched++; $display("FAIL reset_drop got %0d want 0", bus.drop_cnt); end
    if (bus.in_ready !== 1'b1)  begin mismatched++; $display("FAIL reset_ready got %b want 1", bus.in_ready); end
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_single();
    logic [FB-1:0] got, want;
    int k = 0, starts = 0;
    want = '0; want[0] = 1'b1;
`ifdef FIB_SER_PARITY_EN
    want[FB-1] = 1'b1;
`endif
    got = '0;
    for (int c = 0; c < FB + 4; c++) begin
      tick(c == 0, 8'h01, 1'b1);
      compared += 4;
      if (bus.ser_valid !== m_busy) begin mismatched++; $display("FAIL single_valid got %b want %b", bus.ser_valid, m_busy); end
      if (bus.ser_start !== (m_busy && m_pos == 0)) begin mismatched++; $display("FAIL single_start got %b", bus.ser_start); end
      if (bus.in_ready !== (mq.size() < DEPTH)) begin mismatched++; $display("FAIL single_ready got %b", bus.in_ready); end
      if (bus.drop_cnt !== 8'(m_drops)) begin mismatched++; $display("FAIL single_drop got %0d want %0d", bus.drop_cnt, m_drops); end
      if (m_busy) begin
        compared++;
        if (bus.ser_out !== m_frame[m_pos]) begin mismatched++; $display("FAIL single_out got %b want %b", bus.ser_out, m_frame[m_pos]); end
      end
      if (bus.ser_valid === 1'b1 && k < FB) begin got[k] = bus.ser_out; k++; end
      if (bus.ser_start === 1'b1) starts++;
    end
    compared += 4;
    if (got !== want)           begin mismatched++; $display("FAIL single_bits got %b want %b", got, want); end
    if (k != FB)                begin mismatched++; $display("FAIL single_len got %0d want %0d", k, FB); end
    if (starts != 1)            begin mismatched++; $display("FAIL single_starts got %0d want 1", starts); end
    if (bus.ser_valid !== 1'b0) begin mismatched++; $display("FAIL single_end_valid got %b want 0", bus.ser_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] src [3];
    logic [7:0] b;
    bit bq[$];
    int starts = 0, vcnt = 0, last_start = -1;
    bit seen = 0, gap = 0;
    src[0] = 8'h02; src[1] = 8'h03; src[2] = 8'h05;
    for (int c = 0; c < 3 * FB + 6; c++) begin
      tick(c < 3, (c < 3) ? src[c] : 8'h00, 1'b1);
      compared += 4;
      if (bus.ser_valid !== m_busy) begin mismatched++; $display("FAIL b2b_valid got %b want %b", bus.ser_valid, m_busy); end
      if (bus.ser_start !== (m_busy && m_pos == 0)) begin mismatched++; $display("FAIL b2b_start got %b", bus.ser_start); end
      if (bus.in_ready !== (mq.size() < DEPTH)) begin mismatched++; $display("FAIL b2b_ready got %b", bus.in_ready); end
      if (bus.drop_cnt !== 8'(m_drops)) begin mismatched++; $display("FAIL b2b_drop got %0d want %0d", bus.drop_cnt, m_drops); end
      if (m_busy) begin
        compared++;
        if (bus.ser_out !== m_frame[m_pos]) begin mismatched++; $display("FAIL b2b_out got %b want %b", bus.ser_out, m_frame[m_pos]); end
      end
      if (bus.ser_valid === 1'b1) begin vcnt++; bq.push_back(bus.ser_out); end
      else if (seen && vcnt < 3 * FB) gap = 1;
      if (bus.ser_valid === 1'b1) seen = 1;
      if (bus.ser_start === 1'b1) begin
        if (last_start >= 0) begin
          compared++;
          if (c - last_start != FB) begin mismatched++; $display("FAIL b2b_spacing got %0d want %0d", c - last_start, FB); end
        end
        last_start = c;
        starts++;
      end
    end
    compared += 3;
    if (starts != 3)     begin mismatched++; $display("FAIL b2b_starts got %0d want 3", starts); end
    if (vcnt != 3 * FB)  begin mismatched++; $display("FAIL b2b_vcnt got %0d want %0d", vcnt, 3 * FB); end
    if (gap)             begin mismatched++; $display("FAIL b2b_gap got 1 want 0"); end
    for (int f = 0; f < 3; f++) begin
      b = '0;
      for (int k = 0; k < 8; k++) if (f * FB + k < bq.size()) b[k] = bq[f * FB + k];
      compared++;
      if (b !== src[f]) begin mismatched++; $display("FAIL b2b_byte%0d got %h want %h", f, b, src[f]); end
    end
  endtask

  task automatic test_stall();
    logic [7:0]    b;
    logic [FB-1:0] got, want;
    logic          p_out, p_start;
    bit            r;
    int            k = 0;
    b    = 8'($urandom);
    want = mk_frame(b);
    got  = '0;
    tick(1'b1, b, 1'b1);
    for (int c = 0; c < FB + 10; c++) begin
      r = !(c >= 3 && c < 8);
      if (bus.ser_valid === 1'b1 && r && k < FB) begin got[k] = bus.ser_out; k++; end
      p_out = bus.ser_out; p_start = bus.ser_start;
      tick(1'b0, 8'h00, r);
      compared += 2;
      if (bus.ser_valid !== m_busy) begin mismatched++; $display("FAIL stall_valid got %b want %b", bus.ser_valid, m_busy); end
      if (bus.ser_start !== (m_busy && m_pos == 0)) begin mismatched++; $display("FAIL stall_start got %b", bus.ser_start); end
      if (m_busy) begin
        compared++;
        if (bus.ser_out !== m_frame[m_pos]) begin mismatched++; $display("FAIL stall_out got %b want %b", bus.ser_out, m_frame[m_pos]); end
      end
      if (!r) begin
        compared += 2;
        if (bus.ser_out !== p_out)     begin mismatched++; $display("FAIL stall_hold_out got %b want %b", bus.ser_out, p_out); end
        if (bus.ser_start !== p_start) begin mismatched++; $display("FAIL stall_hold_start got %b want %b", bus.ser_start, p_start); end
      end
    end
    compared += 2;
    if (got !== want) begin mismatched++; $display("FAIL stall_frame got %b want %b", got, want); end
    if (k != FB)      begin mismatched++; $display("FAIL stall_len got %0d want %0d", k, FB); end
  endtask

  task automatic test_overflow();
    logic [7:0] src [5];
    logic [7:0] d, b;
    bit bq[$];
    src[0] = 8'($urandom);
    tick(1'b1, src[0], 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      if (i < 4) src[i + 1] = d;
      tick(1'b1, d, 1'b0);
      compared += 2;
      if (bus.in_ready !== (i < 3)) begin mismatched++; $display("FAIL ovf_ready%0d got %b want %b", i, bus.in_ready, i < 3); end
      if (bus.drop_cnt !== 8'(m_drops)) begin mismatched++; $display("FAIL ovf_drop_model got %0d want %0d", bus.drop_cnt, m_drops); end
    end
    compared++;
    if (bus.drop_cnt !== 8'd2) begin mismatched++; $display("FAIL ovf_drop got %0d want 2", bus.drop_cnt); end
    for (int c = 0; c < (DEPTH + 1) * FB + 4; c++) begin
      if (bus.ser_valid === 1'b1) bq.push_back(bus.ser_out);
      tick(1'b0, 8'h00, 1'b1);
      compared++;
      if (bus.ser_valid !== m_busy) begin mismatched++; $display("FAIL ovf_valid got %b want %b", bus.ser_valid, m_busy); end
    end
    compared++;
    if (bq.size() != 5 * FB) begin mismatched++; $display("FAIL ovf_bits got %0d want %0d", bq.size(), 5 * FB); end
    for (int f = 0; f < 5; f++) begin
      b = '0;
      for (int k = 0; k < 8; k++) if (f * FB + k < bq.size()) b[k] = bq[f * FB + k];
      compared++;
      if (b !== src[f]) begin mismatched++; $display("FAIL ovf_byte%0d got %h want %h", f, b, src[f]); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      tick($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 3) == 0);
      compared += 4;
      if (bus.ser_valid !== m_busy) begin mismatched++; $display("FAIL rand_valid c%0d got %b want %b", c, bus.ser_valid, m_busy); end
      if (bus.ser_start !== (m_busy && m_pos == 0)) begin mismatched++; $display("FAIL rand_start c%0d got %b", c, bus.ser_start); end
      if (bus.in_ready !== (mq.size() < DEPTH)) begin mismatched++; $display("FAIL rand_ready c%0d got %b", c, bus.in_ready); end
      if (bus.drop_cnt !== 8'(m_drops)) begin mismatched++; $display("FAIL rand_drop c%0d got %0d want %0d", c, bus.drop_cnt, m_drops); end
      if (m_busy) begin
        compared++;
        if (bus.ser_out !== m_frame[m_pos]) begin mismatched++; $display("FAIL rand_out c%0d got %b want %b", c, bus.ser_out, m_frame[m_pos]); end
      end
    end
  endtask

  task automatic test_saturate();
    for (int c = 0; c < 300; c++) begin
      tick(1'b1, 8'($urandom), 1'b0);
      compared++;
      if (bus.drop_cnt !== 8'(m_drops)) begin mismatched++; $display("FAIL sat_drop c%0d got %0d want %0d", c, bus.drop_cnt, m_drops); end
    end
    compared++;
    if (bus.drop_cnt !== 8'd255) begin mismatched++; $display("FAIL sat_final got %0d want 255", bus.drop_cnt); end
    for (int c = 0; c < (DEPTH + 1) * FB + 4; c++) tick(1'b0, 8'h00, 1'b1);
    compared++;
    if (bus.ser_valid !== 1'b0) begin mismatched++; $display("FAIL sat_drain got %b want 0", bus.ser_valid); end
  endtask

  task automatic test_reset_midframe();
    tick(1'b1, 8'($urandom), 1'b1);
    tick(1'b1, 8'($urandom), 1'b1);
    for (int c = 0; c < 3; c++) tick(1'b0, 8'h00, 1'b1);
    compared++;
    if (bus.ser_valid !== 1'b1) begin mismatched++; $display("FAIL rstmid_pre_valid got %b want 1", bus.ser_valid); end
    #2 rst = 1'b0;
    #1;
    model_reset();
    compared += 4;
    if (bus.ser_valid !== 1'b0) begin mismatched++; $display("FAIL rstmid_valid got %b want 0", bus.ser_valid); end
    if (bus.drop_cnt !== 8'd0)  begin mismatched++; $display("FAIL rstmid_drop got %0d want 0", bus.drop_cnt); end
    if (bus.in_ready !== 1'b1)  begin mismatched++; $display("FAIL rstmid_ready got %b want 1", bus.in_ready); end
    if (bus.ser_start !== 1'b0) begin mismatched++; $display("FAIL rstmid_start got %b want 0", bus.ser_start); end
    @(negedge clk) rst = 1'b1;
    for (int c = 0; c < 2 * FB; c++) begin
      tick(1'b0, 8'h00, 1'b1);
      compared++;
      if (bus.ser_valid !== 1'b0) begin mismatched++; $display("FAIL rstmid_stale c%0d got %b want 0", c, bus.ser_valid); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_random();
    test_saturate();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
